// File: rtl/uart_rx_port.sv
// uart_rx_port: memory-mapped UART receiver holding the last byte for the CPU.
// Ports: clk, rst (async high), rx (serial in), uart_read_end (CPU read strobe),
//   uart_data {24'b0,byte}, int_sig (accept pulse), rx_valid, overrun, frame_err.
// Optional macro UART_RX_PARITY_EN selects 8E1 frames; undefined gives 8N1.
`timescale 1ns/1ps
module uart_rx_port #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic        uart_read_end,
  output logic [31:0] uart_data,
  output logic        int_sig,
  output logic        rx_valid,
  output logic        overrun,
  output logic        frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  // The IDLE detection edge is the first cycle of the half bit, so the
  // start sample lands CLKS_PER_BIT/2 cycles after rxs falls.
  localparam logic [CW-1:0] HALF_LD = CW'(CLKS_PER_BIT / 2 - 2);
  localparam logic [CW-1:0] FULL_LD = CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT_IDLE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, WAIT_IDLE
  } state_t;
`endif

  state_t          state;
  logic            rx_meta;
  logic            rxs;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic [7:0]      rx_byte;
  logic            acc;
`ifdef UART_RX_PARITY_EN
  logic            par_err;
`endif

  assign uart_data = {24'b0, rx_byte};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_byte   <= '0;
      acc       <= 1'b0;
      int_sig   <= 1'b0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err   <= 1'b0;
`endif
    end else begin
      int_sig <= 1'b0;
      acc     <= 1'b0;

      if (uart_read_end) begin
        rx_valid  <= 1'b0;
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end

      // Accept is applied after the read release so it wins a same-cycle read.
      if (acc) begin
        rx_byte   <= shreg;
        rx_valid  <= 1'b1;
        int_sig   <= 1'b1;
        frame_err <= 1'b0;
        if (rx_valid && !uart_read_end)
          overrun <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (!rxs) begin
            cnt   <= HALF_LD;
            state <= START;
          end
        end
        START: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (rxs) begin
            state <= IDLE;
          end else begin
            cnt     <= FULL_LD;
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            shreg   <= {rxs, shreg[7:1]};
            cnt     <= FULL_LD;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            par_err <= rxs ^ (^shreg);
            cnt     <= FULL_LD;
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (rxs && !par_err) begin
`else
          end else if (rxs) begin
`endif
            acc   <= 1'b1;
            state <= IDLE;
          end else begin
            frame_err <= 1'b1;
            state     <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (rxs)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_port.sv
// tb_uart_rx_port: directed bench for uart_rx_port with CLKS_PER_BIT = 16.
// Frames are driven bit by bit; an edge monitor counts int_sig pulses.
`timescale 1ns/1ps
module tb_uart_rx_port;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif
  // 2 sync cycles from rx to rxs, then half bit + NB bits + accept edge.
  localparam int LAT = 2 + CPB / 2 + NB * CPB + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic        uart_read_end = 1'b0;
  logic [31:0] uart_data;
  logic        int_sig;
  logic        rx_valid;
  logic        overrun;
  logic        frame_err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int int_cnt = 0;
  int rise_cyc = 0;
  logic valid_q = 1'b0;

  uart_rx_port #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .uart_read_end(uart_read_end),
    .uart_data(uart_data),
    .int_sig(int_sig),
    .rx_valid(rx_valid),
    .overrun(overrun),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (int_sig) int_cnt = int_cnt + 1;
    if (rx_valid && !valid_q) rise_cyc = cyc;
    valid_q = rx_valid;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop,
                           input logic par_ok);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ ~par_ok;
    repeat (CPB) @(negedge clk);
    rx = stop;
`else
    rx = stop & par_ok;
`endif
    repeat (CPB) @(negedge clk);
  endtask

  task automatic pulse_read;
    uart_read_end = 1'b1;
    @(negedge clk);
    uart_read_end = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (uart_data !== 32'h0) begin
      fails++; $display("FAIL reset_data: got %h want %h", uart_data, 32'h0);
    end
    tests++;
    if (int_sig !== 1'b0) begin
      fails++; $display("FAIL reset_int: got %b want 0", int_sig);
    end
    tests++;
    if (rx_valid !== 1'b0) begin
      fails++; $display("FAIL reset_valid: got %b want 0", rx_valid);
    end
    tests++;
    if (overrun !== 1'b0) begin
      fails++; $display("FAIL reset_overrun: got %b want 0", overrun);
    end
    tests++;
    if (frame_err !== 1'b0) begin
      fails++; $display("FAIL reset_ferr: got %b want 0", frame_err);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_glitch;
    int c;
    c = int_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    tests++;
    if (int_cnt !== c) begin
      fails++; $display("FAIL glitch_int: got %0d pulses want 0", int_cnt - c);
    end
    tests++;
    if ({rx_valid, overrun, frame_err} !== 3'b000) begin
      fails++;
      $display("FAIL glitch_flags: got %b want 000",
               {rx_valid, overrun, frame_err});
    end
    tests++;
    if (uart_data !== 32'h0) begin
      fails++; $display("FAIL glitch_data: got %h want 0", uart_data);
    end
  endtask

  task automatic test_basic;
    int c;
    int c0;
    c = int_cnt;
    c0 = cyc;
    send_byte(8'hA5, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    tests++;
    if (int_cnt !== c + 1) begin
      fails++; $display("FAIL basic_int: got %0d pulse cycles want 1", int_cnt - c);
    end
    tests++;
    if (rx_valid !== 1'b1) begin
      fails++; $display("FAIL basic_valid: got %b want 1", rx_valid);
    end
    tests++;
    if (uart_data !== 32'h0000_00A5) begin
      fails++; $display("FAIL basic_data: got %h want 000000a5", uart_data);
    end
    tests++;
    if (rise_cyc - c0 !== LAT) begin
      fails++; $display("FAIL basic_latency: got %0d want %0d", rise_cyc - c0, LAT);
    end
  endtask

  task automatic test_overrun;
    pulse_read();
    send_byte(8'h3C, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    tests++;
    if (overrun !== 1'b0) begin
      fails++; $display("FAIL ovr_first: got %b want 0", overrun);
    end
    send_byte(8'hC3, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    tests++;
    if (overrun !== 1'b1) begin
      fails++; $display("FAIL ovr_set: got %b want 1", overrun);
    end
    tests++;
    if (uart_data !== 32'h0000_00C3) begin
      fails++; $display("FAIL ovr_data: got %h want 000000c3", uart_data);
    end
    pulse_read();
    tests++;
    if ({rx_valid, overrun} !== 2'b00) begin
      fails++; $display("FAIL ovr_clear: got %b want 00", {rx_valid, overrun});
    end
    tests++;
    if (uart_data !== 32'h0000_00C3) begin
      fails++; $display("FAIL ovr_keep: got %h want 000000c3", uart_data);
    end
  endtask

  task automatic test_read_align;
    int c;
    send_byte(8'h22, 1'b1, 1'b1);
    c = int_cnt;
    fork
      send_byte(8'h11, 1'b1, 1'b1);
      begin
        repeat (LAT - 1) @(negedge clk);
        uart_read_end = 1'b1;
        @(negedge clk);
        uart_read_end = 1'b0;
      end
    join
    repeat (2) @(negedge clk);
    tests++;
    if ({rx_valid, overrun} !== 2'b10) begin
      fails++; $display("FAIL align_flags: got %b want 10", {rx_valid, overrun});
    end
    tests++;
    if (int_cnt !== c + 1) begin
      fails++; $display("FAIL align_int: got %0d pulse cycles want 1", int_cnt - c);
    end
    tests++;
    if (uart_data !== 32'h0000_0011) begin
      fails++; $display("FAIL align_data: got %h want 00000011", uart_data);
    end
  endtask

  task automatic test_frame_err;
    int c;
    pulse_read();
    c = int_cnt;
    send_byte(8'hF0, 1'b0, 1'b1);
    repeat (40) @(negedge clk);
    tests++;
    if (frame_err !== 1'b1) begin
      fails++; $display("FAIL ferr_set: got %b want 1", frame_err);
    end
    tests++;
    if (int_cnt !== c) begin
      fails++; $display("FAIL ferr_int: got %0d pulses want 0", int_cnt - c);
    end
    tests++;
    if ({rx_valid, uart_data} !== {1'b0, 32'h0000_0011}) begin
      fails++;
      $display("FAIL ferr_data: got %b/%h want 0/00000011", rx_valid, uart_data);
    end
    rx = 1'b1;
    repeat (8) @(negedge clk);
    send_byte(8'h55, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    tests++;
    if ({rx_valid, uart_data} !== {1'b1, 32'h0000_0055}) begin
      fails++;
      $display("FAIL ferr_recover: got %b/%h want 1/00000055", rx_valid, uart_data);
    end
    tests++;
    if (int_cnt !== c + 1) begin
      fails++; $display("FAIL ferr_recover_int: got %0d want 1", int_cnt - c);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int c;
    pulse_read();
    c = int_cnt;
    send_byte(8'h07, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    tests++;
    if ({rx_valid, frame_err, uart_data} !== {2'b10, 32'h0000_0007}) begin
      fails++;
      $display("FAIL par_good: got %b%b/%h want 10/00000007",
               rx_valid, frame_err, uart_data);
    end
    tests++;
    if (int_cnt !== c + 1) begin
      fails++; $display("FAIL par_good_int: got %0d want 1", int_cnt - c);
    end
    pulse_read();
    c = int_cnt;
    send_byte(8'h07, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    tests++;
    if ({rx_valid, frame_err} !== 2'b01) begin
      fails++; $display("FAIL par_bad: got %b want 01", {rx_valid, frame_err});
    end
    tests++;
    if (int_cnt !== c) begin
      fails++; $display("FAIL par_bad_int: got %0d want 0", int_cnt - c);
    end
  endtask
`endif

  task automatic test_reset_midframe;
    send_byte(8'h69, 1'b1, 1'b1);
    fork
      send_byte(8'h5A, 1'b1, 1'b1);
      begin
        repeat (60) @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if ({uart_data, int_sig, rx_valid, overrun, frame_err} !== 36'h0) begin
          fails++;
          $display("FAIL midrst_outputs: got %h/%b%b%b%b want 0", uart_data,
                   int_sig, rx_valid, overrun, frame_err);
        end
      end
    join
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    send_byte(8'h81, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    tests++;
    if ({rx_valid, uart_data} !== {1'b1, 32'h0000_0081}) begin
      fails++;
      $display("FAIL midrst_after: got %b/%h want 1/00000081", rx_valid, uart_data);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_basic();
    test_overrun();
    test_read_align();
    test_frame_err();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
